// File: rtl/sram_responder_if.sv
// SRAM controller address/control lines plus responder status.
// The data bus stays a plain inout on the responder.
interface sram_responder_if;
  logic [16:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  logic        proto_err;
  logic        busy;

  modport master (
    output SRAM_ADDR,
    output SRAM_WE_N,
    input  rd_count,
    input  wr_count,
    input  proto_err,
    input  busy
  );

  modport slave (
    input  SRAM_ADDR,
    input  SRAM_WE_N,
    output rd_count,
    output wr_count,
    output proto_err,
    output busy
  );
endinterface

// File: rtl/sram_responder.sv
// Behavioural SRAM responder: latency-qualified reads/writes
// on a tristate data bus with protocol-error tracking.
module sram_responder #(
  parameter int DEPTH  = 2048,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  sram_responder_if.slave   bus,
  inout  wire  [31:0]       SRAM_DQ
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR_WAIT,
    WR_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [16:0] cap_addr_q, cap_addr_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic        proto_err_q, proto_err_d;
  logic        mem_we, go_wr, go_rd;
  logic        addr_hit, dq_oe;
  logic [31:0] mem [DEPTH];

  assign addr_hit = (bus.SRAM_ADDR == cap_addr_q);
  assign cnt_inc  = cnt_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    cap_addr_d  = cap_addr_q;
    cnt_d       = cnt_q;
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    proto_err_d = proto_err_q;
    mem_we      = 1'b0;
    go_wr       = 1'b0;
    go_rd       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.SRAM_WE_N) go_wr = 1'b1;
        else                go_rd = 1'b1;
      end
      RD_WAIT: begin
        if (!bus.SRAM_WE_N) go_wr = 1'b1;
        else if (!addr_hit) go_rd = 1'b1;
        else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= 16'(RD_LAT)) begin
            state_d    = RD_DRIVE;
            rd_count_d = rd_count_q + 16'd1;
          end
        end
      end
      RD_DRIVE: begin
        if (!bus.SRAM_WE_N) go_wr = 1'b1;
        else if (!addr_hit) go_rd = 1'b1;
      end
      WR_WAIT: begin
        if (bus.SRAM_WE_N) begin
          proto_err_d = 1'b1;
          go_rd       = 1'b1;
        end else if (!addr_hit) begin
          proto_err_d = 1'b1;
          cap_addr_d  = bus.SRAM_ADDR;
          cnt_d       = 16'd1;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= 16'(WR_LAT)) begin
            mem_we     = 1'b1;
            wr_count_d = wr_count_q + 16'd1;
            state_d    = WR_HOLD;
          end
        end
      end
      WR_HOLD: begin
        if (bus.SRAM_WE_N)  go_rd = 1'b1;
        else if (!addr_hit) go_wr = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Fresh capture, shared by every path that restarts a transaction
    if (go_wr) begin
      cap_addr_d = bus.SRAM_ADDR;
      cnt_d      = 16'd1;
      if (WR_LAT == 1) begin
        mem_we     = 1'b1;
        wr_count_d = wr_count_q + 16'd1;
        state_d    = WR_HOLD;
      end else begin
        state_d = WR_WAIT;
      end
    end
    if (go_rd) begin
      cap_addr_d = bus.SRAM_ADDR;
      cnt_d      = 16'd1;
      if (RD_LAT == 1) begin
        rd_count_d = rd_count_q + 16'd1;
        state_d    = RD_DRIVE;
      end else begin
        state_d = RD_WAIT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cap_addr_q  <= '0;
      cnt_q       <= '0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_addr_q  <= cap_addr_d;
      cnt_q       <= cnt_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Array is never reset; a commit racing reset is dropped
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[cap_addr_d[AW-1:0]] <= SRAM_DQ;
  end

  assign dq_oe = (state_q == RD_DRIVE) && bus.SRAM_WE_N && addr_hit;
  assign SRAM_DQ = dq_oe ? mem[cap_addr_q[AW-1:0]] : 32'bz;

  assign bus.rd_count  = rd_count_q;
  assign bus.wr_count  = wr_count_q;
  assign bus.proto_err = proto_err_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: read data is scoreboarded,
// counters, flags and bus release are checked inline.
module tb_sram_responder;
  localparam int DEPTH = 2048;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_responder_if bus();
  wire  [31:0] SRAM_DQ;
  logic        tb_oe = 1'b0;
  logic [31:0] tb_dq = '0;
  assign SRAM_DQ = tb_oe ? tb_dq : 32'bz;

  sram_responder #(
    .DEPTH(DEPTH),
    .RD_LAT(2),
    .WR_LAT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .SRAM_DQ(SRAM_DQ)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic        oe_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each new drive episode pops one expected word
  always @(negedge clk) begin
    if (dut.dq_oe && !oe_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_data: unexpected drive %h", SRAM_DQ);
      end else begin
        chk("rd_data", SRAM_DQ, exp_q.pop_front());
      end
    end
    oe_prev = dut.dq_oe;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [16:0] a, input logic [31:0] d);
    bus.SRAM_ADDR = a;
    bus.SRAM_WE_N = 1'b0;
    tb_dq = d;
    tb_oe = 1'b1;
    step(3);
  endtask

  task automatic rd(input logic [16:0] a, input logic [31:0] d);
    exp_q.push_back(d);
    tb_oe = 1'b0;
    bus.SRAM_WE_N = 1'b1;
    bus.SRAM_ADDR = a;
    step(2);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    tb_oe = 1'b0;
    bus.SRAM_WE_N = 1'b1;
    rst = 1'b1;
    #2;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rd_count", 32'(bus.rd_count), 32'd0);
    chk("rst_wr_count", 32'(bus.wr_count), 32'd0);
    chk("rst_proto_err", 32'(bus.proto_err), 32'd0);
    chk("rst_hiz", 32'(dut.dq_oe), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    bus.SRAM_ADDR = '0;
    bus.SRAM_WE_N = 1'b1;
    do_reset();

    // Basic write then read
    wr(17'd5, 32'hDEADBEEF);
    chk("w5_wr_count", 32'(bus.wr_count), 32'd1);
    rd(17'd5, 32'hDEADBEEF);
    chk("r5_rd_count", 32'(bus.rd_count), 32'd1);
    chk("r5_proto_err", 32'(bus.proto_err), 32'd0);

    // Aliasing
    wr(17'd7, 32'hA5A5A5A5);
    rd(17'(DEPTH + 7), 32'hA5A5A5A5);

    // Back-to-back writes, address changes under WE_N low
    do_reset();
    wr(17'd0, 32'h11110000);
    wr(17'd1, 32'h22220001);
    chk("b2b_wr_count", 32'(bus.wr_count), 32'd2);
    chk("b2b_proto_err", 32'(bus.proto_err), 32'd0);
    rd(17'd0, 32'h11110000);
    rd(17'd1, 32'h22220001);

    wr(17'd9, 32'h0BADF00D);
    wr(17'd4, 32'h44444444);
    wr(17'd2, 32'h22222222);

    // Aborted write
    do_reset();
    bus.SRAM_ADDR = 17'd9;
    bus.SRAM_WE_N = 1'b0;
    tb_dq = 32'h12345678;
    tb_oe = 1'b1;
    step(1);
    rd(17'd9, 32'h0BADF00D);
    chk("abort_proto_err", 32'(bus.proto_err), 32'd1);
    chk("abort_wr_count", 32'(bus.wr_count), 32'd0);
    chk("abort_rd_count", 32'(bus.rd_count), 32'd1);
    rd(17'd2, 32'h22222222);
    chk("sticky_proto_err", 32'(bus.proto_err), 32'd1);

    // Read address changes before latency expires
    do_reset();
    bus.SRAM_ADDR = 17'd3;
    step(1);
    chk("a3_hiz", 32'(dut.dq_oe), 32'd0);
    bus.SRAM_ADDR = 17'd4;
    step(1);
    chk("a4_hiz", 32'(dut.dq_oe), 32'd0);
    chk("a4_rd_count0", 32'(bus.rd_count), 32'd0);
    exp_q.push_back(32'h44444444);
    step(1);
    chk("a4_rd_count1", 32'(bus.rd_count), 32'd1);
    step(3);
    chk("a4_rd_once", 32'(bus.rd_count), 32'd1);

    // Reset during WR_WAIT discards the write
    do_reset();
    bus.SRAM_ADDR = 17'd2;
    bus.SRAM_WE_N = 1'b0;
    tb_dq = 32'hFFFFFFFF;
    tb_oe = 1'b1;
    step(1);
    chk("ww_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #2;
    chk("ww_rst_hiz", 32'(dut.dq_oe), 32'd0);
    chk("ww_rst_wr", 32'(bus.wr_count), 32'd0);
    chk("ww_rst_rd", 32'(bus.rd_count), 32'd0);
    chk("ww_rst_busy", 32'(bus.busy), 32'd0);
    tb_oe = 1'b0;
    bus.SRAM_WE_N = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    rd(17'd2, 32'h22222222);
    chk("ww_wr_count", 32'(bus.wr_count), 32'd0);

    @(negedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
